// File: rtl/fp_pkg.sv
// Shared FP32 constants, field-packing type and normalisation FSM states
// used across the adder/multiplier pipeline stages.
package fp_pkg;

   localparam int EXP_W    = 8;
   localparam int MANT_W   = 23;
   localparam int EXP_BIAS = 127;
   localparam logic [EXP_W-1:0] EXP_INF = 8'hFF;
   localparam logic [4:0]       MAX_LSH = 5'd23;

   typedef enum logic [1:0] {IDLE, NORM, PACK, DONE} norm_state_t;

   typedef struct packed {
      logic              sign;
      logic [EXP_W-1:0]  exp;
      logic [MANT_W-1:0] mant;
   } fp32_t;

endpackage

// File: rtl/normalization_if.sv
// Handshake/data bundle between the mantissa-addition stage (master)
// and the normalisation stage (slave).
interface normalization_if;
   import fp_pkg::*;

   logic [MANT_W+1:0] mantissa_sum;
   logic [EXP_W-1:0]  add_new_exponent;
   logic              sign_result;
   logic              done_2;
   logic [31:0]       result;
   logic              done_3;
   logic              overflow;

   modport master (
      output mantissa_sum, add_new_exponent, sign_result, done_2,
      input  result, done_3, overflow
   );

   modport slave (
      input  mantissa_sum, add_new_exponent, sign_result, done_2,
      output result, done_3, overflow
   );
endinterface

// File: rtl/fp_round_ne.sv
// Round-to-nearest-even increment on the 23-bit fraction using a single
// guard bit; o_carry flags a fraction wrap needing renormalisation.
`ifdef NORM_ROUND_EN
module fp_round_ne
   import fp_pkg::*;
(
   input  logic [MANT_W-1:0] i_frac,
   input  logic              i_guard,
   output logic [MANT_W-1:0] o_frac,
   output logic              o_carry
);
   logic w_inc;

   assign w_inc             = i_guard & i_frac[0];
   assign {o_carry, o_frac} = {1'b0, i_frac} + {{MANT_W{1'b0}}, w_inc};
endmodule
`endif

// File: rtl/normalization.sv
// FP32 adder stage 3: iterative normalisation of the raw mantissa sum and
// IEEE-754 packing. Define NORM_ROUND_EN for round-to-nearest-even in PACK.
module normalization
   import fp_pkg::*;
(
   input  logic            clk,
   input  logic            reset,
   normalization_if.slave  bus
);
   norm_state_t       r_state, w_state_nxt;
   logic              r_done2_q;
   logic [MANT_W+1:0] r_mant, w_mant_nxt;
   logic [EXP_W:0]    r_exp, w_exp_nxt;
   logic              r_sign, w_sign_nxt;
   logic              r_denorm, w_denorm_nxt;
   logic [4:0]        r_shifts, w_shifts_nxt;
   logic [31:0]       r_result, w_result_nxt;
   logic              r_done3, w_done3_nxt;
   logic              r_overflow, w_overflow_nxt;

   logic              w_start;
   logic [MANT_W-1:0] w_frac_pk;
   logic              w_carry;
   logic [EXP_W:0]    w_exp_pk;
   fp32_t             w_pk;

   assign w_start = bus.done_2 & ~r_done2_q;

`ifdef NORM_ROUND_EN
   logic r_guard;

   // Guard bit only exists when a right shift dropped a bit this operation.
   always_ff @(posedge clk) begin
      if (reset)
         r_guard <= 1'b0;
      else if (w_start)
         r_guard <= 1'b0;
      else if (r_state == NORM && r_mant != '0 && r_mant[MANT_W+1])
         r_guard <= r_mant[0];
   end

   fp_round_ne u_round (
      .i_frac  (r_mant[MANT_W-1:0]),
      .i_guard (r_guard),
      .o_frac  (w_frac_pk),
      .o_carry (w_carry)
   );
`else
   assign w_frac_pk = r_mant[MANT_W-1:0];
   assign w_carry   = 1'b0;
`endif

   // A denormal whose fraction wraps becomes the smallest normal (exp 1).
   assign w_exp_pk = r_denorm ? {{EXP_W{1'b0}}, w_carry}
                              : r_exp + {{EXP_W{1'b0}}, w_carry};

   always_comb begin
      w_pk.sign = r_sign;
      w_pk.exp  = w_exp_pk[EXP_W-1:0];
      w_pk.mant = w_frac_pk;
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_mant_nxt     = r_mant;
      w_exp_nxt      = r_exp;
      w_sign_nxt     = r_sign;
      w_denorm_nxt   = r_denorm;
      w_shifts_nxt   = r_shifts;
      w_result_nxt   = r_result;
      w_done3_nxt    = r_done3;
      w_overflow_nxt = r_overflow;

      if (w_start) begin
         w_mant_nxt     = bus.mantissa_sum;
         w_exp_nxt      = {1'b0, bus.add_new_exponent};
         w_sign_nxt     = bus.sign_result;
         w_denorm_nxt   = 1'b0;
         w_shifts_nxt   = '0;
         w_done3_nxt    = 1'b0;
         w_overflow_nxt = 1'b0;
         w_state_nxt    = NORM;
      end else begin
         case (r_state)
            NORM: begin
               if (r_mant == '0) begin
                  w_denorm_nxt = 1'b1;
                  w_state_nxt  = PACK;
               end else if (r_mant[MANT_W+1]) begin
                  w_mant_nxt  = r_mant >> 1;
                  w_exp_nxt   = r_exp + 9'd1;
                  w_state_nxt = PACK;
               end else if (r_mant[MANT_W]) begin
                  w_state_nxt = PACK;
               end else if (r_exp <= 9'd1) begin
                  w_denorm_nxt = 1'b1;
                  w_state_nxt  = PACK;
               end else if (r_shifts == MAX_LSH) begin
                  w_state_nxt = PACK;
               end else begin
                  w_mant_nxt   = r_mant << 1;
                  w_exp_nxt    = r_exp - 9'd1;
                  w_shifts_nxt = r_shifts + 5'd1;
               end
            end
            PACK: begin
               if (w_exp_pk >= {1'b0, EXP_INF}) begin
                  w_result_nxt   = {r_sign, EXP_INF, {MANT_W{1'b0}}};
                  w_overflow_nxt = 1'b1;
               end else begin
                  w_result_nxt = w_pk;
               end
               w_done3_nxt = 1'b1;
               w_state_nxt = DONE;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= IDLE;
         r_done2_q  <= 1'b0;
         r_mant     <= '0;
         r_exp      <= '0;
         r_sign     <= 1'b0;
         r_denorm   <= 1'b0;
         r_shifts   <= '0;
         r_result   <= '0;
         r_done3    <= 1'b0;
         r_overflow <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_done2_q  <= bus.done_2;
         r_mant     <= w_mant_nxt;
         r_exp      <= w_exp_nxt;
         r_sign     <= w_sign_nxt;
         r_denorm   <= w_denorm_nxt;
         r_shifts   <= w_shifts_nxt;
         r_result   <= w_result_nxt;
         r_done3    <= w_done3_nxt;
         r_overflow <= w_overflow_nxt;
      end
   end

   assign bus.result   = r_result;
   assign bus.done_3   = r_done3;
   assign bus.overflow = r_overflow;
endmodule
